potential_decay: RTL and testbench
==================================

Name: potential_decay

Overview:
- Applies per-timestep membrane-potential leak to one IEEE-754 single-precision neuron potential.
- Sits in the neuron update pipeline, between potential storage and the spike/threshold stage.
- Decay is a power-of-two leak: V_out = V − V·2^−decay_rate, computed as an exponent shift followed by an FP subtraction.
- Registered output, one-cycle latency.

Parameters:
- MODEL_LIF, 2'b00, model code for which decay is applied.
- FLUSH_DENORM, 1, when 1, subnormal inputs and results are treated as ±0.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- clear  input  1  synchronous active-low reset; 0 at a rising edge zeroes the output register.
- model  input  2  neuron model select; 00 = LIF (decay applied), others = pass-through.
- decay_rate  input  3  leak shift r; decay factor is (1 − 2^−r).
- input_potential  input  32  current membrane potential, IEEE-754 single.
- output_potential  output  32  decayed potential, IEEE-754 single, registered.

Behaviour:
- Reset value: output_potential = 32'h0000_0000 on any rising CLK edge with clear = 0. Reset has priority over all other inputs.
- Latency: with clear = 1, output_potential at edge k+1 reflects the inputs sampled at edge k.
  - Fully pipelined: a new input is accepted every cycle.
  - No handshake and no internal state besides the output register.
- Function (evaluated combinationally, then registered):
  - model != 00: output = input_potential, bit-exact.
  - model == 00 and decay_rate == 0: output = input_potential (r = 0 means no decay).
  - model == 00, r in 1..7: D = input·2^−r, formed by subtracting r from the biased exponent. Output = input − D, computed with a full FP subtract (align, subtract, normalise, round-to-nearest-even). Sign is preserved, because |D| < |input|.
- Special operands:
  - ±0 input → same ±0 output.
  - Subnormal input (exp = 0, frac ≠ 0) → flushed to +0 when FLUSH_DENORM = 1.
  - exp − r ≤ 0 (D underflows) → D treated as 0, output = input.
  - Inf or NaN input (exp = 255) → output = input unchanged.
  - Result that would be subnormal → +0 (flush).
- Arithmetic:
  - Internal mantissa datapath: at least 24 bits plus guard, round and sticky bits (≥27 bits).
  - Rounding is round-to-nearest, ties-to-even.
  - Result exponent ≥ input exponent − 1, so no overflow is possible.
- Inputs may change every cycle, and clear may deassert at any cycle. The first valid output appears one edge after clear returns to 1.

Test Plan:
- Reset: clear = 0 for one edge with input 32'h4120_0000 → output 32'h0000_0000. Set clear = 1, model = 00, r = 1 → next edge output 32'h40A0_0000 (10.0 → 5.0).
- Rate sweep on 10.0 (32'h4120_0000), model 00:
  - r = 0 → 32'h4120_0000.
  - r = 2 → 32'h40F0_0000 (7.5).
  - r = 3 → 32'h410C_0000 (8.75).
- Sign and small values:
  - −10.0 (32'hC120_0000), r = 3 → 32'hC10C_0000.
  - 4.0 (32'h4080_0000), r = 1 → 32'h4000_0000.
  - +0 → +0.
- Model select: model = 01, 10 and 11 with 10.0, r = 1 → 32'h4120_0000 each.
- Specials:
  - +Inf 32'h7F80_0000 → 32'h7F80_0000.
  - NaN 32'h7FC0_0000 → 32'h7FC0_0000.
  - 32'h0080_0000 (min normal), r = 1 → D underflows, output 32'h0080_0000.
- Timestep pattern: clear low 1 of every 4 cycles for 100 ns with constant 10.0, r = 1.
  - Output is 0 after each reset edge.
  - Output is 32'h40A0_0000 on every other edge.
  - Throughput: back-to-back input changes each produce a one-cycle-late result.

Source files
------------

// File: rtl/potential_decay.sv
// potential_decay: one-cycle power-of-two membrane leak on an IEEE-754 single.
// V_out = V - V*2^-r. D = V*2^-r is formed by an exponent shift.
// The subtraction is then done exactly on a widened mantissa, normalised and
// rounded to nearest-even. The result is registered.
module potential_decay #(
    parameter logic [1:0] MODEL_LIF    = 2'b00,
    parameter bit         FLUSH_DENORM = 1'b1
) (
    input  logic        CLK,
    input  logic        clear,
    input  logic [1:0]  model,
    input  logic [2:0]  decay_rate,
    input  logic [31:0] input_potential,
    output logic [31:0] output_potential
);

    // Round-to-nearest-even on a 24-bit mantissa. The extra top bit flags
    // carry-out into the exponent.
    function automatic logic [24:0] round_rne(input logic [23:0] mant,
                                              input logic        guard,
                                              input logic        sticky);
        logic inc;
        inc = guard & (sticky | mant[0]);
        return {1'b0, mant} + {24'd0, inc};
    endfunction

    logic        w_sign;
    logic [7:0]  w_exp;
    logic [22:0] w_frac;
    logic [33:0] w_a;
    logic [33:0] w_b;
    logic [33:0] w_diff;
    logic [33:0] w_norm;
    logic [8:0]  w_exp_norm;
    logic [24:0] w_mant_rnd;
    logic [8:0]  w_exp_res;
    logic [31:0] w_decayed;
    logic [31:0] w_next;
    logic [31:0] r_out;

    assign w_sign = input_potential[31];
    assign w_exp  = input_potential[30:23];
    assign w_frac = input_potential[22:0];

    // Datapath for V - V*2^-r. There are 10 spare low bits and r <= 7, so
    // the aligned D keeps every bit. The difference is exact before rounding.
    // Since |D| <= |V|/2, the difference loses at most one leading bit.
    always_comb begin
        w_a        = {1'b1, w_frac, 10'd0};
        w_b        = w_a >> decay_rate;
        w_diff     = w_a - w_b;
        w_norm     = w_diff[33] ? w_diff : (w_diff << 1);
        w_exp_norm = w_diff[33] ? {1'b0, w_exp} : ({1'b0, w_exp} - 9'd1);
        w_mant_rnd = round_rne(w_norm[33:10], w_norm[9], |w_norm[8:0]);
        w_exp_res  = w_exp_norm + {8'd0, w_mant_rnd[24]};
        if (w_exp_res == 9'd0) begin
            w_decayed = 32'h0000_0000;
        end else begin
            w_decayed = {w_sign, w_exp_res[7:0],
                         (w_mant_rnd[24] ? 23'd0 : w_mant_rnd[22:0])};
        end
    end

    // Select pass-through, flush, or decayed value for the output register.
    always_comb begin
        w_next = input_potential;
        if (model == MODEL_LIF) begin
            if (w_exp == 8'hFF) begin
                w_next = input_potential;
            end else if (w_exp == 8'd0) begin
                if (w_frac != 23'd0 && FLUSH_DENORM) begin
                    w_next = 32'h0000_0000;
                end else begin
                    w_next = input_potential;
                end
            end else if (decay_rate == 3'd0 || {5'd0, decay_rate} >= w_exp) begin
                // No decay, or D is too small to be a normal number.
                w_next = input_potential;
            end else begin
                w_next = w_decayed;
            end
        end
    end

    // Output register. An active-low clear wins over everything else.
    always_ff @(posedge CLK) begin
        if (!clear) begin
            r_out <= 32'h0000_0000;
        end else begin
            r_out <= w_next;
        end
    end

    assign output_potential = r_out;

endmodule

// File: tb/tb_potential_decay.sv
// Directed bench for potential_decay. Expected values are worked out by hand.
module tb_potential_decay;

    logic        CLK;
    logic        clear;
    logic [1:0]  model;
    logic [2:0]  decay_rate;
    logic [31:0] input_potential;
    logic [31:0] output_potential;

    int total;
    int bad;

    potential_decay dut (
        .CLK              (CLK),
        .clear            (clear),
        .model            (model),
        .decay_rate       (decay_rate),
        .input_potential  (input_potential),
        .output_potential (output_potential)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drive one set of inputs, clock once, and check the registered result.
    task automatic step(input logic clr, input logic [1:0] mdl, input logic [2:0] r,
                        input logic [31:0] vin, input logic [31:0] expv, input string tag);
        clear           = clr;
        model           = mdl;
        decay_rate      = r;
        input_potential = vin;
        @(posedge CLK);
        #1;
        total++;
        assert (output_potential === expv) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, output_potential, expv);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clear = 1'b0;
        model = 2'b00;
        decay_rate = 3'd0;
        input_potential = 32'h0;
        @(negedge CLK);

        step(1'b0, 2'b00, 3'd1, 32'h4120_0000, 32'h0000_0000, "reset");
        step(1'b1, 2'b00, 3'd1, 32'h4120_0000, 32'h40A0_0000, "first_r1");
        step(1'b1, 2'b00, 3'd0, 32'h4120_0000, 32'h4120_0000, "r0");
        step(1'b1, 2'b00, 3'd2, 32'h4120_0000, 32'h40F0_0000, "r2");
        step(1'b1, 2'b00, 3'd3, 32'h4120_0000, 32'h410C_0000, "r3");
        step(1'b1, 2'b00, 3'd3, 32'hC120_0000, 32'hC10C_0000, "neg_r3");
        step(1'b1, 2'b00, 3'd1, 32'h4080_0000, 32'h4000_0000, "four_r1");
        step(1'b1, 2'b00, 3'd2, 32'h0000_0000, 32'h0000_0000, "pos_zero");
        step(1'b1, 2'b00, 3'd2, 32'h8000_0000, 32'h8000_0000, "neg_zero");
        step(1'b1, 2'b01, 3'd1, 32'h4120_0000, 32'h4120_0000, "model01");
        step(1'b1, 2'b10, 3'd1, 32'h4120_0000, 32'h4120_0000, "model10");
        step(1'b1, 2'b11, 3'd1, 32'h4120_0000, 32'h4120_0000, "model11");
        step(1'b1, 2'b00, 3'd1, 32'h7F80_0000, 32'h7F80_0000, "inf");
        step(1'b1, 2'b00, 3'd1, 32'h7FC0_0000, 32'h7FC0_0000, "nan");
        step(1'b1, 2'b00, 3'd1, 32'h0080_0000, 32'h0080_0000, "min_normal");
        step(1'b1, 2'b00, 3'd1, 32'h0040_0000, 32'h0000_0000, "subnormal_flush");
        // (1+2^-23)*0.75 = 0.75 + 1.5 ulp; the tie rounds to the even value +2 ulp.
        step(1'b1, 2'b00, 3'd2, 32'h3F80_0001, 32'h3F40_0002, "rne_tie");
        // r=7 on 128.0: 128 - 1 = 127.0
        step(1'b1, 2'b00, 3'd7, 32'h4300_0000, 32'h42FE_0000, "r7");
        step(1'b1, 2'b01, 3'd7, 32'h0040_0000, 32'h0040_0000, "subn_passthru");

        // Timestep pattern: clear low on one cycle in four, with a constant input.
        for (int i = 0; i < 12; i++) begin
            if (i % 4 == 0)
                step(1'b0, 2'b00, 3'd1, 32'h4120_0000, 32'h0000_0000, "ts_reset");
            else
                step(1'b1, 2'b00, 3'd1, 32'h4120_0000, 32'h40A0_0000, "ts_decay");
        end

        // Back-to-back changes; each result appears one cycle later.
        step(1'b1, 2'b00, 3'd2, 32'h4120_0000, 32'h40F0_0000, "b2b_0");
        step(1'b1, 2'b00, 3'd1, 32'h4080_0000, 32'h4000_0000, "b2b_1");
        step(1'b1, 2'b00, 3'd3, 32'hC120_0000, 32'hC10C_0000, "b2b_2");
        step(1'b1, 2'b10, 3'd3, 32'hC120_0000, 32'hC120_0000, "b2b_3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
